// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] HALT_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers and occupancy; flush discards any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale contents are masked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[tail] <= wdata;
  end

  assign rdata = mem[head];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, queues fetched words for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(PC_STEP * ROM_WORDS);

  logic [PC_W-1:0]            pc;
  logic                       pop;
  logic                       can_push;
  logic                       end_of_prog;
  logic                       push;
  fetch_entry_t               head_entry;
  fetch_entry_t               new_entry;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic                       q_full;
  logic                       q_empty;

  assign rom_addr    = pc[9:2];
  assign pop         = out_valid && out_ready;
  assign can_push    = !halted && !redirect_valid && (!q_full || pop);
  assign end_of_prog = (rom_data == HALT_INSTR) || (pc >= PC_LIMIT);
  assign push        = can_push && !end_of_prog;
  assign new_entry   = '{pc: pc, instr: rom_data};

  // PC / halt control: redirect outranks everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~PC_W'(3);
      halted <= 1'b0;
    end else if (can_push) begin
      if (end_of_prog) halted <= 1'b1;
      else             pc     <= pc + PC_W'(PC_STEP);
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (new_entry),
    .rdata (head_entry),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Head is zeroed when empty so decode never sees stale storage.
  assign out_valid = (q_count != '0);
  assign out_instr = q_empty ? '0 : head_entry.instr;
  assign out_pc    = q_empty ? '0 : head_entry.pc;

endmodule
